sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 152 +++++++++++++++
 tb/tb_sync_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock FIFO with block-RAM storage.
//
// Storage is a plain array with one synchronous write port and one registered
// read port. Depth need not be a power of two; pointers wrap explicitly.
// Two output modes:
//   FWFT = 0 : rd_data_o is loaded on the edge that accepts a read.
//   FWFT = 1 : the head word is pre-fetched into an output register and held
//              on rd_data_o while empty_o = 0; rd_en_i pops it.
//
// Ports
//   clk            : clock, all state changes on its rising edge
//   rst_n          : asynchronous active-low reset
//   wr_en_i        : write request (ignored while full_o = 1)
//   wr_data_i      : write data
//   rd_en_i        : read request / pop (ignored while empty_o = 1)
//   rd_data_o      : read data
//   full_o         : count_o == MEM_DEPTH
//   empty_o        : nothing to read
//   almost_full_o  : count_o >= AFULL_THRESH
//   almost_empty_o : count_o <= AEMPTY_THRESH
//   count_o        : occupancy, including the presented word in FWFT mode
//   overflow_o     : one-cycle pulse after a write request while full
//   underflow_o    : one-cycle pulse after a read request while empty
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 150,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = MEM_DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i,
    input  logic                           rd_en_i,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           almost_full_o,
    output logic                           almost_empty_o,
    output logic [$clog2(MEM_DEPTH+1)-1:0] count_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int CW = $clog2(MEM_DEPTH + 1);
    localparam int PW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [PW-1:0] LAST_PTR = PW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(MEM_DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    // Illegal parameter sets stop elaboration.
    generate
        if (MEM_DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo: MEM_DEPTH must be >= 2");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("sync_fifo: FWFT must be 0 or 1");
        end
        if (AFULL_THRESH < 1 || AFULL_THRESH > MEM_DEPTH) begin : g_bad_afull
            $error("sync_fifo: AFULL_THRESH must be in 1..MEM_DEPTH");
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > MEM_DEPTH - 1) begin : g_bad_aempty
            $error("sync_fifo: AEMPTY_THRESH must be in 0..MEM_DEPTH-1");
        end
    endgenerate

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_ok, rd_ok, mem_rd, mem_has;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Status flags decode straight from the registered count.
    assign full_o         = (count_q == DEPTH_C);
    assign almost_full_o  = (count_q >= AFULL_C);
    assign almost_empty_o = (count_q <= AEMPTY_C);
    assign empty_o        = (FWFT == 1) ? ~out_valid_q : (count_q == '0);
    assign count_o        = count_q;
    assign rd_data_o      = rd_data_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // In FWFT mode count_q includes the presented word, so words still in
    // the array are count_q minus out_valid_q.
    assign mem_has = (count_q > {{(CW-1){1'b0}}, out_valid_q});

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_ok       = wr_en_i & ~full_o;
        rd_ok       = rd_en_i & ~empty_o;
        mem_rd      = rd_ok;
        out_valid_d = 1'b0;
        if (FWFT == 1) begin
            // Refill the output register when it is empty or being popped.
            mem_rd      = mem_has & (~out_valid_q | rd_ok);
            out_valid_d = mem_rd | (out_valid_q & ~rd_ok);
        end
    end

    // NOTE: the storage array has no reset; clearing it would stop the
    // tools mapping it onto block RAM, and pointers/count already make
    // stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (mem_rd) begin
                rd_ptr_q  <= next_ptr(rd_ptr_q);
                rd_data_q <= mem[rd_ptr_q];
            end
            out_valid_q <= out_valid_d;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow_q  <= wr_en_i & full_o;
            underflow_q <= rd_en_i & empty_o;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo -- drives a standard-mode (a) and an FWFT-mode (b) sync_fifo
// with identical stimulus and compares both against queue-based models.
// FWFT model: a word is presented once it was written on an edge strictly
// before the most recent one, and it is the oldest word in the FIFO.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    logic [DW-1:0] rd_data_a, rd_data_b;
    logic          full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
    logic          full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
    logic [2:0]    count_a, count_b;

    sync_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(D), .FWFT(0),
                .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_data_o(rd_data_a), .full_o(full_a),
        .empty_o(empty_a), .almost_full_o(afull_a), .almost_empty_o(aempty_a),
        .count_o(count_a), .overflow_o(ovf_a), .underflow_o(unf_a));

    sync_fifo #(.DATA_WIDTH(DW), .MEM_DEPTH(D), .FWFT(1),
                .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_data_o(rd_data_b), .full_o(full_b),
        .empty_o(empty_b), .almost_full_o(afull_b), .almost_empty_o(aempty_b),
        .count_o(count_b), .overflow_o(ovf_b), .underflow_o(unf_b));

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            wr_edge;
    } entry_t;

    logic [DW-1:0] mq_a[$];
    entry_t        mq_b[$];
    logic [DW-1:0] exp_rd_a;
    bit            exp_ovf_a, exp_unf_a, exp_ovf_b, exp_unf_b;
    int            last_edge = 0;
    int            checks = 0;
    int            errors = 0;

    function automatic bit head_valid_b();
        return (mq_b.size() > 0) && (mq_b[0].wr_edge < last_edge);
    endfunction

    task automatic reset_model();
        mq_a.delete();
        mq_b.delete();
        exp_rd_a  = '0;
        exp_ovf_a = 0; exp_unf_a = 0; exp_ovf_b = 0; exp_unf_b = 0;
    endtask

    // One clock cycle: drive at negedge, update models at posedge, compare at
    // the following negedge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
        bit full_m_a, empty_m_a, full_m_b, valid_m_b, vb;
        full_m_a  = (mq_a.size() == D);
        empty_m_a = (mq_a.size() == 0);
        full_m_b  = (mq_b.size() == D);
        valid_m_b = head_valid_b();
        exp_ovf_a = w && full_m_a;
        exp_unf_a = r && empty_m_a;
        exp_ovf_b = w && full_m_b;
        exp_unf_b = r && !valid_m_b;
        wr_en = w; wr_data = d; rd_en = r;
        @(posedge clk);
        last_edge++;
        if (r && !empty_m_a) exp_rd_a = mq_a.pop_front();
        if (w && !full_m_a)  mq_a.push_back(d);
        if (r && valid_m_b)  mq_b.delete(0);
        if (w && !full_m_b)  mq_b.push_back('{data: d, wr_edge: last_edge});
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        vb = head_valid_b();
        checks++; if (count_a !== 3'(mq_a.size())) begin errors++; $display("FAIL count_a got %0d exp %0d", count_a, mq_a.size()); end
        checks++; if (full_a !== (mq_a.size() == D)) begin errors++; $display("FAIL full_a got %b exp %b", full_a, mq_a.size() == D); end
        checks++; if (empty_a !== (mq_a.size() == 0)) begin errors++; $display("FAIL empty_a got %b exp %b", empty_a, mq_a.size() == 0); end
        checks++; if (afull_a !== (mq_a.size() >= AF)) begin errors++; $display("FAIL afull_a got %b exp %b", afull_a, mq_a.size() >= AF); end
        checks++; if (aempty_a !== (mq_a.size() <= AE)) begin errors++; $display("FAIL aempty_a got %b exp %b", aempty_a, mq_a.size() <= AE); end
        checks++; if (ovf_a !== exp_ovf_a) begin errors++; $display("FAIL ovf_a got %b exp %b", ovf_a, exp_ovf_a); end
        checks++; if (unf_a !== exp_unf_a) begin errors++; $display("FAIL unf_a got %b exp %b", unf_a, exp_unf_a); end
        checks++; if (rd_data_a !== exp_rd_a) begin errors++; $display("FAIL rd_data_a got %h exp %h", rd_data_a, exp_rd_a); end
        checks++; if (count_b !== 3'(mq_b.size())) begin errors++; $display("FAIL count_b got %0d exp %0d", count_b, mq_b.size()); end
        checks++; if (full_b !== (mq_b.size() == D)) begin errors++; $display("FAIL full_b got %b exp %b", full_b, mq_b.size() == D); end
        checks++; if (empty_b !== !vb) begin errors++; $display("FAIL empty_b got %b exp %b", empty_b, !vb); end
        checks++; if (afull_b !== (mq_b.size() >= AF)) begin errors++; $display("FAIL afull_b got %b exp %b", afull_b, mq_b.size() >= AF); end
        checks++; if (aempty_b !== (mq_b.size() <= AE)) begin errors++; $display("FAIL aempty_b got %b exp %b", aempty_b, mq_b.size() <= AE); end
        checks++; if (ovf_b !== exp_ovf_b) begin errors++; $display("FAIL ovf_b got %b exp %b", ovf_b, exp_ovf_b); end
        checks++; if (unf_b !== exp_unf_b) begin errors++; $display("FAIL unf_b got %b exp %b", unf_b, exp_unf_b); end
        if (vb) begin
            checks++; if (rd_data_b !== mq_b[0].data) begin errors++; $display("FAIL rd_data_b got %h exp %h", rd_data_b, mq_b[0].data); end
        end
    endtask

    // Assert reset between edges, check outputs before the next edge, hold
    // for two edges and release on a falling edge.
    task automatic test_reset();
        wr_en = 1'b0; rd_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (count_a !== 3'd0 || count_b !== 3'd0) begin errors++; $display("FAIL reset_count got %0d/%0d exp 0/0", count_a, count_b); end
        checks++; if (empty_a !== 1'b1 || empty_b !== 1'b1) begin errors++; $display("FAIL reset_empty got %b/%b exp 1/1", empty_a, empty_b); end
        checks++; if (full_a !== 1'b0 || full_b !== 1'b0) begin errors++; $display("FAIL reset_full got %b/%b exp 0/0", full_a, full_b); end
        checks++; if (afull_a !== 1'b0 || afull_b !== 1'b0) begin errors++; $display("FAIL reset_afull got %b/%b exp 0/0", afull_a, afull_b); end
        checks++; if (aempty_a !== 1'b1 || aempty_b !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b/%b exp 1/1", aempty_a, aempty_b); end
        checks++; if (rd_data_a !== '0 || rd_data_b !== '0) begin errors++; $display("FAIL reset_rd_data got %h/%h exp 00/00", rd_data_a, rd_data_b); end
        checks++; if ({ovf_a, unf_a, ovf_b, unf_b} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {ovf_a, unf_a, ovf_b, unf_b}); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] v;
        for (int i = 1; i <= 5; i++) begin
            v = DW'(i * 17);
            step(1'b1, v, 1'b0);
        end
        checks++; if (full_a !== 1'b1 || count_a !== 3'd5) begin errors++; $display("FAIL fill full/count got %b/%0d exp 1/5", full_a, count_a); end
        step(1'b1, 8'h66, 1'b0);
        checks++; if (ovf_a !== 1'b1 || ovf_b !== 1'b1) begin errors++; $display("FAIL overflow_pulse got %b/%b exp 1/1", ovf_a, ovf_b); end
        step(1'b0, 8'h00, 1'b0);
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL overflow_single got %b exp 0", ovf_a); end
        for (int i = 1; i <= 5; i++) begin
            v = DW'(i * 17);
            step(1'b0, 8'h00, 1'b1);
            checks++; if (rd_data_a !== v) begin errors++; $display("FAIL drain_a[%0d] got %h exp %h", i, rd_data_a, v); end
        end
        checks++; if (empty_a !== 1'b1 || empty_b !== 1'b1) begin errors++; $display("FAIL drained_empty got %b/%b exp 1/1", empty_a, empty_b); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] v;
        for (int i = 0; i < 12; i++) begin
            v = DW'($urandom);
            step(1'b1, v, 1'b0);
            step(1'b0, 8'h00, 1'b1);
            checks++; if (rd_data_a !== v) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, rd_data_a, v); end
            checks++; if (count_a > 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp <=2", i, count_a); end
        end
        while (mq_b.size() > 0) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        checks++; if (count_a !== 3'd4 || ovf_a !== 1'b1) begin errors++; $display("FAIL simul_full count/ovf got %0d/%b exp 4/1", count_a, ovf_a); end
        while (mq_a.size() > 0 || mq_b.size() > 0) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b1);
        checks++; if (count_a !== 3'd1 || unf_a !== 1'b1) begin errors++; $display("FAIL simul_empty count/unf got %0d/%b exp 1/1", count_a, unf_a); end
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        checks++; if (rd_data_a !== 8'h3C) begin errors++; $display("FAIL simul_empty_data got %h exp 3c", rd_data_a); end
    endtask

    task automatic test_fwft_latency();
        step(1'b1, 8'hA5, 1'b0);
        checks++; if (empty_b !== 1'b1) begin errors++; $display("FAIL fwft_edge_n empty got %b exp 1", empty_b); end
        step(1'b0, 8'h00, 1'b0);
        checks++; if (empty_b !== 1'b0 || rd_data_b !== 8'hA5) begin errors++; $display("FAIL fwft_edge_n1 empty/data got %b/%h exp 0/a5", empty_b, rd_data_b); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (empty_b !== 1'b1 || count_b !== 3'd0) begin errors++; $display("FAIL fwft_pop empty/count got %b/%0d exp 1/0", empty_b, count_b); end
    endtask

    task automatic test_thresholds();
        for (int n = 1; n <= 5; n++) begin
            step(1'b1, DW'(n), 1'b0);
            checks++; if (aempty_a !== (n <= 1)) begin errors++; $display("FAIL thresh_aempty[%0d] got %b exp %b", n, aempty_a, n <= 1); end
            checks++; if (afull_a !== (n >= 4)) begin errors++; $display("FAIL thresh_afull[%0d] got %b exp %b", n, afull_a, n >= 4); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0);
        test_reset();
        step(1'b1, 8'h77, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        checks++; if (rd_data_b !== 8'h77) begin errors++; $display("FAIL post_reset_b got %h exp 77", rd_data_b); end
        step(1'b0, 8'h00, 1'b1);
        checks++; if (rd_data_a !== 8'h77) begin errors++; $display("FAIL post_reset_a got %h exp 77", rd_data_a); end
    endtask

    task automatic test_random();
        int wp[4] = '{70, 30, 50, 90};
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 100; c++) begin
                step($urandom_range(0, 99) < wp[p], DW'($urandom),
                     $urandom_range(0, 99) < 60);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_fwft_latency();
        test_thresholds();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
